// File: rtl/binary_search_unit.sv
// Binary search over a 2**AW x DW block RAM holding ascending data.
// The host loads and reads back the RAM while idle. Each search probe takes two cycles: PROBE issues the read, CMP compares.
module binary_search_unit #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] datain,
    input  logic [DW-1:0] key,
    output logic [DW-1:0] dataout,
    output logic          ready,
    output logic          found,
    output logic [AW-1:0] idx
);

    localparam int N = 1 << AW;
    localparam logic [AW-1:0] MID_MAX = AW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        CMP
    } state_t;

    state_t        state_reg, state_next;
    logic [AW:0]   lo_reg, lo_next;
    logic [AW:0]   hi_reg, hi_next;
    logic [AW-1:0] mid_reg, mid_next;
    logic [AW-1:0] idx_reg, idx_next;
    logic [DW-1:0] key_reg, key_next;
    logic          found_reg, found_next;

    logic [DW-1:0] mem [0:N-1];
    logic [DW-1:0] dataout_reg;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;

    // lo/hi carry one extra bit so lo can reach N without wrapping.
    logic [AW:0]   mid_ext;
    logic [AW:0]   lo_inc;
    logic [AW:0]   hi_dec;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= IDLE;
            lo_reg    <= '0;
            hi_reg    <= '0;
            mid_reg   <= '0;
            idx_reg   <= '0;
            key_reg   <= '0;
            found_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            mid_reg   <= mid_next;
            idx_reg   <= idx_next;
            key_reg   <= key_next;
            found_reg <= found_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        mid_next   = mid_reg;
        idx_next   = idx_reg;
        key_next   = key_reg;
        found_next = found_reg;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = addr;
        mid_ext    = {1'b0, mid_reg};
        lo_inc     = mid_ext + 1'b1;
        hi_dec     = mid_ext - 1'b1;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    key_next   = key;
                    lo_next    = '0;
                    hi_next    = (AW + 1)'(N - 1);
                    found_next = 1'b0;
                    idx_next   = '0;
                    state_next = PROBE;
                end else if (wr) begin
                    mem_we = 1'b1;
                end else begin
                    mem_re = 1'b1;
                end
            end

            PROBE: begin
                // The sum of two in-range indices fits in AW+1 bits.
                mid_next   = AW'((lo_reg + hi_reg) >> 1);
                mem_addr   = AW'((lo_reg + hi_reg) >> 1);
                mem_re     = 1'b1;
                state_next = CMP;
            end

            CMP: begin
                if (dataout_reg == key_reg) begin
                    found_next = 1'b1;
                    idx_next   = mid_reg;
                    state_next = IDLE;
                end else if (dataout_reg < key_reg) begin
                    if (mid_reg == MID_MAX) begin
                        state_next = IDLE;
                    end else begin
                        lo_next    = lo_inc;
                        state_next = (lo_inc > hi_reg) ? IDLE : PROBE;
                    end
                end else begin
                    if (mid_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        hi_next    = hi_dec;
                        state_next = (lo_reg > hi_dec) ? IDLE : PROBE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // No reset here: contents survive nrst and map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= datain;
        end
        if (mem_re) begin
            dataout_reg <= mem[mem_addr];
        end
    end

    assign dataout = dataout_reg;
    assign ready   = (state_reg == IDLE);
    assign found   = found_reg;
    assign idx     = idx_reg;

endmodule

// File: tb/tb_binary_search_unit.sv
// Self-checking bench for binary_search_unit.
// The reference model is a plain integer binary search over a shadow copy of the RAM.
module tb_binary_search_unit;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] datain = '0;
    logic [DW-1:0] key = '0;
    logic [DW-1:0] dataout;
    logic          ready;
    logic          found;
    logic [AW-1:0] idx;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] ref_mem [N];

    binary_search_unit #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .wr      (wr),
        .addr    (addr),
        .datain  (datain),
        .key     (key),
        .dataout (dataout),
        .ready   (ready),
        .found   (found),
        .idx     (idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Textbook binary search; the probe count gives the expected busy time.
    function automatic void ref_search(input logic [DW-1:0] k, output bit f, output int ix,
                                       output int probes, output int last_mid);
        int lo = 0;
        int hi = N - 1;
        int mid;
        f = 1'b0;
        ix = 0;
        probes = 0;
        last_mid = 0;
        while (lo <= hi) begin
            mid = (lo + hi) / 2;
            probes++;
            last_mid = mid;
            if (ref_mem[mid] == k) begin
                f = 1'b1;
                ix = mid;
                break;
            end else if (ref_mem[mid] < k) begin
                lo = mid + 1;
            end else begin
                hi = mid - 1;
            end
        end
    endfunction

    task automatic host_write(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        addr   = AW'(a);
        datain = d;
        wr     = 1'b1;
        @(negedge clk);
        wr     = 1'b0;
    endtask

    task automatic load_all();
        for (int a = 0; a < N; a++) begin
            host_write(a, ref_mem[a]);
        end
    endtask

    task automatic readback_all(input string tag);
        for (int a = 0; a < N; a++) begin
            @(negedge clk);
            addr = AW'(a);
            wr   = 1'b0;
            @(negedge clk);
            check(tag, 32'(dataout), 32'(ref_mem[a]));
        end
    endtask

    task automatic search(input logic [DW-1:0] k, input bit noisy, input bit wr_at_start);
        bit f;
        int ix, pr, lm, cnt;
        ref_search(k, f, ix, pr, lm);
        @(negedge clk);
        start = 1'b1;
        key   = k;
        if (wr_at_start) begin
            wr     = 1'b1;
            addr   = '0;
            datain = 8'd99;
        end
        @(negedge clk);
        start = 1'b0;
        wr    = 1'b0;
        check("found_cleared_on_start", 32'(found), 32'd0);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 64) begin
            cnt++;
            if (noisy) begin
                wr     = 1'($urandom_range(0, 1));
                start  = 1'($urandom_range(0, 1));
                addr   = AW'($urandom);
                datain = DW'($urandom);
                key    = DW'($urandom);
            end
            @(negedge clk);
        end
        wr    = 1'b0;
        start = 1'b0;
        check("busy_cycles", 32'(cnt), 32'(2 * pr));
        check("found", 32'(found), 32'(f));
        check("idx", 32'(idx), 32'(ix));
        check("last_probed_word", 32'(dataout), 32'(ref_mem[lm]));
        $display("search key=%0d found=%0d idx=%0d busy=%0d", k, found, idx, cnt);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_found", 32'(found), 32'd0);
        check("reset_idx", 32'(idx), 32'd0);
        nrst = 1'b1;

        // Directed cases on the reference table
        ref_mem = '{8'd3, 8'd7, 8'd9, 8'd12, 8'd20, 8'd25, 8'd31, 8'd40};
        load_all();
        readback_all("load_readback");
        search(8'd20, 1'b0, 1'b0);
        search(8'd3, 1'b0, 1'b0);
        search(8'd40, 1'b0, 1'b0);
        search(8'd10, 1'b0, 1'b0);
        search(8'd0, 1'b0, 1'b0);
        search(8'd41, 1'b0, 1'b0);

        // A write alongside start and writes while busy must not land
        search(8'd20, 1'b0, 1'b1);
        readback_all("wr_with_start");
        search(8'd31, 1'b1, 1'b0);
        readback_all("wr_while_busy");

        // Reset asserted during the CMP cycle of a search
        @(negedge clk);
        start = 1'b1;
        key   = 8'd25;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_found", 32'(found), 32'd0);
        check("abort_idx", 32'(idx), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        readback_all("abort_readback");
        search(8'd25, 1'b0, 1'b0);

        // Result holds across idle host reads
        search(8'd20, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            addr = AW'(i);
            check("hold_found", 32'(found), 32'd1);
            check("hold_idx", 32'(idx), 32'd4);
        end
        search(8'd12, 1'b0, 1'b0);

        // Random sorted tables (duplicates allowed) with noisy inputs while busy
        for (int t = 0; t < 25; t++) begin
            int run = $urandom_range(0, 20);
            for (int a = 0; a < N; a++) begin
                ref_mem[a] = DW'(run);
                run += $urandom_range(0, 30);
            end
            load_all();
            for (int s = 0; s < 4; s++) begin
                logic [DW-1:0] k;
                if ($urandom_range(0, 1) == 1) k = ref_mem[$urandom_range(0, N - 1)];
                else k = DW'($urandom);
                search(k, 1'($urandom_range(0, 1)), 1'b0);
            end
            readback_all("random_readback");
        end

        // Unsorted tables: must still terminate, result follows the midpoint walk
        for (int t = 0; t < 5; t++) begin
            for (int a = 0; a < N; a++) ref_mem[a] = DW'($urandom);
            load_all();
            for (int s = 0; s < 4; s++) begin
                search(ref_mem[$urandom_range(0, N - 1)], 1'b0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
